// File: rtl/airlock_controller.sv
// airlock_controller
// Moore FSM sequencing a two-door airlock. Reads the elapsed-cycle count from
// an external 3-bit at-state counter and issues that counter's clear on
// every state entry. All outputs, including the state, are registered.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset (also clears the counter)
//   inner_req   level request to open the inner (pressurized-side) door
//   outer_req   level request to open the outer (vacuum-side) door
//   abort       level; cancels an evacuation in progress
//   at_count    elapsed cycles from the at-state counter
//   cnt_clr     clear to the at-state counter, high on the first cycle in a state
//   inner_open  inner door open command
//   outer_open  outer door open command
//   pump_evac   evacuation pump on
//   pump_press  pressurization pump on
//   state       current state encoding
module airlock_controller #(
  parameter int unsigned DWELL  = 5,
  parameter int unsigned OPEN_T = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inner_req,
  input  logic       outer_req,
  input  logic       abort,
  input  logic [2:0] at_count,
  output logic       cnt_clr,
  output logic       inner_open,
  output logic       outer_open,
  output logic       pump_evac,
  output logic       pump_press,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    SEALED_IN  = 3'd0,
    OPEN_IN    = 3'd1,
    EVAC       = 3'd2,
    SEALED_OUT = 3'd3,
    OPEN_OUT   = 3'd4,
    PRESS      = 3'd5
  } state_t;

  localparam logic [2:0] DWELL_C = 3'(DWELL);
  localparam logic [2:0] OPEN_C  = 3'(OPEN_T);

  state_t cur, nxt;

  // The counter value is stale during the entry cycle (cnt_clr high), so
  // timed exits only qualify once the clear has dropped.
  logic door_done, pump_done;
  assign door_done = !cnt_clr && (at_count >= OPEN_C);
  assign pump_done = !cnt_clr && (at_count >= DWELL_C);

  always_comb begin
    nxt = cur;
    case (cur)
      SEALED_IN: begin
        if (inner_req)      nxt = OPEN_IN;
        else if (outer_req) nxt = EVAC;
      end
      SEALED_OUT: begin
        if (outer_req)      nxt = OPEN_OUT;
        else if (inner_req) nxt = PRESS;
      end
      OPEN_IN:  if (door_done) nxt = SEALED_IN;
      OPEN_OUT: if (door_done) nxt = SEALED_OUT;
      EVAC: begin
        // abort outranks dwell completion
        if (abort)          nxt = PRESS;
        else if (pump_done) nxt = SEALED_OUT;
      end
      PRESS:    if (pump_done) nxt = SEALED_IN;
      // encodings 6/7: recover to the safe pressurized state
      default:  nxt = SEALED_IN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur        <= SEALED_IN;
      cnt_clr    <= 1'b1;
      inner_open <= 1'b0;
      outer_open <= 1'b0;
      pump_evac  <= 1'b0;
      pump_press <= 1'b0;
    end else begin
      cur        <= nxt;
      // any change of state (including recovery from an illegal code)
      // restarts the counter
      cnt_clr    <= (nxt != cur);
      inner_open <= (nxt == OPEN_IN);
      outer_open <= (nxt == OPEN_OUT);
      pump_evac  <= (nxt == EVAC);
      pump_press <= (nxt == PRESS);
    end
  end

  assign state = cur;

endmodule
